// File: rtl/mem_responder_if.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------+
// | mem_responder_if : memory-port bundle between datapath and RAM   |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
interface mem_responder_if;
  logic        read;
  logic        write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    output read, write, addr, wdata,
    input  rdata, busy, done, err
  );

  modport slave (
    input  read, write, addr, wdata,
    output rdata, busy, done, err
  );
endinterface
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------+
// | mem_responder : word-addressed 32-bit RAM, configurable latency, |
// | single busy/done handshake. Option macro: MEM_RANGE_CHK_EN       |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module mem_responder #(
  parameter int DEPTH   = 512,
  parameter int AW      = 9,
  parameter int LATENCY = 1
) (
  input  logic           clk,
  input  logic           reset,
  mem_responder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic          is_wr_q;
  logic [31:0]   rdata_q;
  logic [31:0]   mem [DEPTH];

  logic          accept;
  logic          commit;
  logic [AW-1:0] acc_addr;
  logic [31:0]   acc_wdata;
  logic          acc_wr;
  logic          acc_oor;

  // With LATENCY==1 the commit edge is also the accept edge, so the
  // access fields come straight from the bus while still in IDLE.
  assign acc_addr  = (state_q == IDLE) ? bus.addr[AW-1:0] : addr_q;
  assign acc_wdata = (state_q == IDLE) ? bus.wdata        : wdata_q;
  assign acc_wr    = (state_q == IDLE) ? bus.write        : is_wr_q;

`ifdef MEM_RANGE_CHK_EN
  logic oor_q;
  logic err_q;
  logic req_oor;

  assign req_oor = |bus.addr[31:AW];
  assign acc_oor = (state_q == IDLE) ? req_oor : oor_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      oor_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (accept) oor_q <= req_oor;
      if (commit)      err_q <= acc_oor;
      else if (accept) err_q <= 1'b0;
    end
  end

  assign bus.err = err_q;
`else
  logic unused_addr_hi;

  assign unused_addr_hi = ^bus.addr[31:AW];
  assign acc_oor        = 1'b0;
  assign bus.err        = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.read || bus.write) begin
          accept = 1'b1;
          cnt_d  = CNT_INIT;
          if (LATENCY == 1) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = RESP;
          commit  = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      is_wr_q <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= bus.addr[AW-1:0];
        wdata_q <= bus.wdata;
        is_wr_q <= bus.write;
      end
      // Read data is loaded on the edge entering RESP so it is valid with done.
      if (commit && !acc_wr)
        rdata_q <= acc_oor ? 32'd0 : mem[acc_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (commit && acc_wr && !acc_oor)
      mem[acc_addr] <= acc_wdata;
  end

  assign bus.rdata = rdata_q;
  assign bus.busy  = (state_q == WAIT);
  assign bus.done  = (state_q == RESP);

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------+
// | tb_mem_responder : bench for mem_responder at LATENCY 1, 4 and 8 |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module tb_mem_responder;

  localparam int NI = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        rd_s [NI];
  logic        wr_s [NI];
  logic [31:0] ad_s [NI];
  logic [31:0] wd_s [NI];
  logic [31:0] rdat [NI];
  logic        bsy  [NI];
  logic        dn   [NI];
  logic        er   [NI];

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int LAT = (gi == 0) ? 1 : (gi == 1) ? 4 : 8;
    mem_responder_if u_if ();
    assign u_if.read  = rd_s[gi];
    assign u_if.write = wr_s[gi];
    assign u_if.addr  = ad_s[gi];
    assign u_if.wdata = wd_s[gi];
    assign rdat[gi]   = u_if.rdata;
    assign bsy[gi]    = u_if.busy;
    assign dn[gi]     = u_if.done;
    assign er[gi]     = u_if.err;
    mem_responder #(.DEPTH(512), .AW(9), .LATENCY(LAT)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (u_if.slave)
    );
  end

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int          inst;
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    bit          r;
    bit          w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [9];

  logic [31:0] last_rd [NI];

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : (i == 1) ? 4 : 8;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One access: push expectation on drive, pop and compare on done.
  task automatic access(input int i, input bit r, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_rd,
                        input logic exp_err, input bit inj);
    exp_t e;
    int   k;
    bit   got;
    @(negedge clk);
    rd_s[i] = r; wr_s[i] = w; ad_s[i] = a; wd_s[i] = d;
    e.inst  = i;
    e.rdata = (r && !w) ? exp_rd : last_rd[i];
    e.err   = exp_err;
    sb.push_back(e);
    if (r && !w) last_rd[i] = exp_rd;
    got = 1'b0;
    k   = 1;
    while (!got && k <= 40) begin
      @(negedge clk);
      if (dn[i]) begin
        got = 1'b1;
        e = sb.pop_front();
        check($sformatf("latency i%0d a%0d", i, a), k, lat_of(e.inst));
        check($sformatf("rdata i%0d a%0d", i, a), rdat[i], e.rdata);
        check($sformatf("err i%0d a%0d", i, a), 32'(er[i]), 32'(e.err));
        check($sformatf("busy_at_done i%0d", i), 32'(bsy[i]), 32'd0);
      end else if (k < lat_of(i)) begin
        check($sformatf("busy i%0d k%0d", i, k), 32'(bsy[i]), 32'd1);
      end
      if (k == 1) begin
        rd_s[i] = 1'b0; wr_s[i] = 1'b0; ad_s[i] = ~a; wd_s[i] = ~d;
        if (inj) begin
          wr_s[i] = 1'b1; ad_s[i] = a + 32'd1; wd_s[i] = 32'hFFFF_0000;
        end
      end else if (k == 2) begin
        wr_s[i] = 1'b0;
      end
      k++;
    end
    if (!got) begin
      n_chk++; n_fail++;
      $display("FAIL timeout i%0d a%0d: no done within 40 cycles", i, a);
      void'(sb.pop_front());
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nd;
    reset = 1'b0;
    for (int i = 0; i < NI; i++) begin
      rd_s[i] = 0; wr_s[i] = 0; ad_s[i] = 0; wd_s[i] = 0; last_rd[i] = 0;
    end
    tbl[0] = '{r:0, w:1, a:32'd90, d:32'd85,         exp:32'd0};
    tbl[1] = '{r:1, w:0, a:32'd90, d:32'd0,          exp:32'd85};
    tbl[2] = '{r:1, w:1, a:32'd3,  d:32'hDEAD_BEEF,  exp:32'd0};
    tbl[3] = '{r:1, w:0, a:32'd3,  d:32'd0,          exp:32'hDEAD_BEEF};
    tbl[4] = '{r:0, w:1, a:32'd10, d:32'h1111_2222,  exp:32'd0};
    tbl[5] = '{r:0, w:1, a:32'd11, d:32'h3333_4444,  exp:32'd0};
    tbl[6] = '{r:1, w:0, a:32'd10, d:32'd0,          exp:32'h1111_2222};
    tbl[7] = '{r:1, w:0, a:32'd11, d:32'd0,          exp:32'h3333_4444};
    tbl[8] = '{r:1, w:0, a:32'd90, d:32'd0,          exp:32'd85};

    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("rst busy i%0d", i),  32'(bsy[i]), 32'd0);
      check($sformatf("rst done i%0d", i),  32'(dn[i]),  32'd0);
      check($sformatf("rst rdata i%0d", i), rdat[i],     32'd0);
      check($sformatf("rst err i%0d", i),   32'(er[i]),  32'd0);
    end
    reset = 1'b1;

    // Contents survive a reset pulse taken while idle.
    access(0, 0, 1, 32'd5, 32'hA5A5_0001, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    #2 reset = 1'b0;
    #1 check("idle rst busy", 32'(bsy[0]), 32'd0);
    #1 reset = 1'b1;
    access(0, 1, 0, 32'd5, 32'd0, 32'hA5A5_0001, 1'b0, 1'b0);

    for (int v = 0; v < 9; v++)
      access(0, tbl[v].r, tbl[v].w, tbl[v].a, tbl[v].d, tbl[v].exp, 1'b0, 1'b0);

    // LATENCY=4: a write strobe during busy is ignored.
    access(1, 0, 1, 32'd20, 32'hCAFE_0020, 32'd0, 1'b0, 1'b0);
    access(1, 0, 1, 32'd21, 32'h0BAD_0021, 32'd0, 1'b0, 1'b0);
    access(1, 1, 0, 32'd20, 32'd0, 32'hCAFE_0020, 1'b0, 1'b1);
    access(1, 1, 0, 32'd21, 32'd0, 32'h0BAD_0021, 1'b0, 1'b0);

    // Level read held high: one completion every two cycles at LATENCY=1.
    @(negedge clk);
    rd_s[0] = 1'b1; ad_s[0] = 32'd90;
    nd = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (dn[0]) begin
        nd++;
        check($sformatf("b2b rdata k%0d", k), rdat[0], 32'd85);
      end
      check($sformatf("b2b done pattern k%0d", k), 32'(dn[0]), 32'(k % 2));
    end
    rd_s[0] = 1'b0;
    last_rd[0] = 32'd85;
    check("b2b done count", nd, 32'd4);

    // LATENCY=8: reset in the third WAIT cycle drops a pending write.
    access(2, 0, 1, 32'd7, 32'h0000_5555, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    wr_s[2] = 1'b1; ad_s[2] = 32'd7; wd_s[2] = 32'h0000_1234;
    @(negedge clk);
    wr_s[2] = 1'b0;
    check("midop busy before", 32'(bsy[2]), 32'd1);
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    #1 check("midop busy after rst", 32'(bsy[2]), 32'd0);
    check("midop done after rst", 32'(dn[2]), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < NI; i++) last_rd[i] = 32'd0;
    nd = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (dn[2]) nd++;
    end
    check("midop no done", nd, 32'd0);
    access(2, 1, 0, 32'd7, 32'd0, 32'h0000_5555, 1'b0, 1'b0);

`ifdef MEM_RANGE_CHK_EN
    access(0, 0, 1, 32'd0,   32'h0000_0A0A, 32'd0, 1'b0, 1'b0);
    access(0, 0, 1, 32'd512, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0);
    @(negedge clk);
    check("err held idle", 32'(er[0]), 32'd1);
    access(0, 1, 0, 32'd0,   32'd0, 32'h0000_0A0A, 1'b0, 1'b0);
    access(0, 1, 0, 32'd600, 32'd0, 32'd0,         1'b1, 1'b0);
`else
    access(0, 0, 1, 32'd0,   32'h0000_0A0A, 32'd0, 1'b0, 1'b0);
    access(0, 0, 1, 32'd512, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
    access(0, 1, 0, 32'd0,   32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    access(0, 0, 1, 32'd600, 32'h0000_0600, 32'd0, 1'b0, 1'b0);
    access(0, 1, 0, 32'd88,  32'd0, 32'h0000_0600, 1'b0, 1'b0);
`endif

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Word-addressed 32-bit RAM that services the datapath's memory port.
- Accepts read/write strobes with the MAR address and MDR write data; returns read data for the MDR mux path (mux select 01).
- Access latency is configurable, so control sequences can be checked against a slow memory.
- Single busy/done handshake; only one outstanding access at a time.

Parameters:
- DEPTH, 512, number of 32-bit words; power of two.
- AW, 9, index width; must equal log2(DEPTH).
- LATENCY, 1, cycles from request acceptance to done pulse; legal range 1..15.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset.
- read  input  1  read strobe from datapath.
- write  input  1  write strobe from datapath.
- addr  input  32  word address (MAR contents).
- wdata  input  32  write data (MDR contents).
- rdata  output  32  read data, the mdatain source.
- busy  output  1  high while an access is in progress.
- done  output  1  one-cycle pulse when an access completes.
- err  output  1  address-range error flag; only present with MEM_RANGE_CHK_EN, otherwise tied 0.

Behaviour:
- Reset (reset=0, asynchronous):
  - State returns to IDLE; busy=0, done=0, err=0, rdata=0, latency counter=0.
  - RAM contents are not cleared.
  - Reset during WAIT drops the pending access; a pending write is never committed.
- States: IDLE, WAIT, RESP.
- IDLE:
  - On a rising edge with read=1 or write=1, the request is accepted.
  - addr[AW-1:0], wdata and the op type are captured.
  - busy=1 from the next cycle; counter loads LATENCY-1.
  - If LATENCY==1, go directly to RESP; otherwise go to WAIT.
- Priority: if read and write are both high at acceptance, the request is a write. The read is dropped and not queued.
- WAIT: counter decrements each cycle; at 0, go to RESP.
- RESP (one cycle):
  - Write: RAM[captured addr] <= captured wdata.
  - Read: rdata <= RAM[captured addr].
  - done=1 for this cycle, busy=0 in the same cycle; next state IDLE.
- Latency: done is asserted LATENCY cycles after the acceptance edge, and rdata is valid in that same cycle.
- Strobes seen while busy or in RESP are ignored. They are not queued; the datapath must re-assert after done.
- Strobes must be held until accepted. A level strobe still high in the IDLE cycle after RESP starts a new access (back-to-back throughput is one access per LATENCY+1 cycles).
- rdata holds its last read value through writes and idle periods; it only changes in the RESP cycle of a read.
- Changes to addr and wdata after acceptance have no effect on the access in progress.
- Address wrap: without the optional feature, the upper address bits [31:AW] are ignored, so addr=DEPTH aliases to word 0.

Optional Feature:
- Macro: MEM_RANGE_CHK_EN.
- Defined:
  - Any accepted request with addr >= DEPTH completes normally (same latency, done pulse), but a write is suppressed and a read returns rdata=32'h0.
  - err=1 in the RESP cycle and stays high until the next accepted request or reset.
- Undefined: no range check; addresses alias as above; err is tied 0.

Test Plan:
- Reset state: after reset=0 then 1 -> busy=0, done=0, rdata=0. Pre-write word 5 = 32'hA5A5_0001, pulse reset mid-idle, then read 5 -> rdata=32'hA5A5_0001 (contents survive reset).
- Write then read, LATENCY=1: write addr=32'd90, wdata=32'd85 -> done one cycle later. Then read addr=90 -> done and rdata=32'd85 in the same cycle, busy high only between acceptance and done.
- Latency LATENCY=4: read accepted at edge N -> busy=1 for edges N+1..N+3, done exactly at N+4. A write strobe pulsed during busy is ignored, and a later read of its address shows the old data.
- Priority and hold: read=1 and write=1 together with addr=3, wdata=32'hDEAD_BEEF -> treated as a write; a subsequent read of 3 returns 32'hDEAD_BEEF. rdata keeps its prior value through that write.
- Reset mid-operation: LATENCY=8, write addr=7, wdata=32'h1234 accepted, reset=0 asserted in the third WAIT cycle -> busy=0 and done=0 immediately, no done pulse. A later read of 7 returns the old value.
- Range (MEM_RANGE_CHK_EN): write addr=512, wdata=32'hFFFF_FFFF -> done with err=1, word 0 unchanged. Read addr=600 -> rdata=0, err=1. Without the macro, write addr=512 lands in word 0.
